// File: rtl/pipeline_type.sv
// Shared types for the fetch PC redirect logic: FSM states, redirect
// priorities, redirect payload and the ADEF exception code.
package pipeline_type;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned ECODE_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } fsm_state_e;

    // Numeric order is the arbitration order: a larger value wins.
    typedef enum logic [1:0] {
        PRIO_NONE   = 2'd0,
        PRIO_PRED   = 2'd1,
        PRIO_BRANCH = 2'd2,
        PRIO_EXCP   = 2'd3
    } redir_prio_e;

    typedef struct packed {
        redir_prio_e       prio;
        logic [ADDR_W-1:0] target;
    } redirect_t;

    localparam redirect_t REDIR_NONE = '{prio: PRIO_NONE, target: '0};

    localparam logic [ECODE_W-1:0] ECODE_ADEF = 7'h08;

    function automatic logic is_flush(input redir_prio_e prio);
        return (prio == PRIO_BRANCH) || (prio == PRIO_EXCP);
    endfunction

endpackage

// File: rtl/redirect_arb.sv
// Fixed-priority pick among the redirect sources for the current cycle.
module redirect_arb
    import pipeline_type::*;
(
    input  logic              excp_flush,
    input  logic [ADDR_W-1:0] excp_target,
    input  logic              branch_flush,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              pred_taken,
    input  logic [ADDR_W-1:0] pred_target,
    input  logic              pred_en,
    output redirect_t         win_c
);

    always_comb begin
        win_c = REDIR_NONE;
        if (excp_flush) begin
            win_c = '{prio: PRIO_EXCP, target: excp_target};
        end else if (branch_flush) begin
            win_c = '{prio: PRIO_BRANCH, target: branch_target};
        end else if (pred_taken && pred_en) begin
            win_c = '{prio: PRIO_PRED, target: pred_target};
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC generator: sequential 8-byte groups, prioritized redirects,
// stall-time redirect buffering and ADEF detection on the fetch address.
module pc_redirect_ctrl
    import pipeline_type::*;
#(
    parameter logic [31:0] PC_RESET_VEC = 32'h1C00_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        excp_flush,
    input  logic [31:0] excp_target,
    input  logic        branch_flush,
    input  logic [31:0] branch_target,
    input  logic        pre_taken_or_not,
    input  logic [31:0] pre_branch_addr,
    output logic [31:0] pc_o_1,
    output logic [31:0] pc_o_2,
    output logic        inst_en_1,
    output logic        inst_en_2,
    output logic        fetch_flush,
    output logic        is_exception,
    output logic [6:0]  exception_cause
);

    fsm_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc2_q, pc2_d;
    logic               en1_q, en1_d;
    logic               en2_q, en2_d;
    logic               flush_q, flush_d;
    logic               exc_q, exc_d;
    logic [ECODE_W-1:0] cause_q, cause_d;
    redirect_t          pend_q, pend_d;
    redirect_t          win;
    logic               pred_en;
    logic [ADDR_W-1:0]  pc_seq;
    logic               aligned;

    // When a buffered redirect is released, the stalled group's prediction is stale.
    assign pred_en = !((state_q == PEND) && !stall);

    redirect_arb u_arb (
        .excp_flush    (excp_flush),
        .excp_target   (excp_target),
        .branch_flush  (branch_flush),
        .branch_target (branch_target),
        .pred_taken    (pre_taken_or_not),
        .pred_target   (pre_branch_addr),
        .pred_en       (pred_en),
        .win_c         (win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (stall && (win.prio != PRIO_NONE)) state_d = PEND;
            PEND:    if (!stall) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    assign pc_seq = pc_q + (pc_q[2] ? 32'd4 : 32'd8);

    always_comb begin
        pc_d    = pc_q;
        pend_d  = pend_q;
        flush_d = 1'b0;
        case (state_q)
            IDLE: begin
                pc_d   = PC_RESET_VEC;
                pend_d = REDIR_NONE;
            end
            RUN: begin
                if (!stall) begin
                    if (win.prio != PRIO_NONE) begin
                        pc_d    = win.target;
                        flush_d = is_flush(win.prio);
                    end else if (pc_q[1:0] == 2'b00) begin
                        pc_d = pc_seq;
                    end
                end else if (win.prio != PRIO_NONE) begin
                    pend_d = win;
                end
            end
            PEND: begin
                if (stall) begin
                    if ((win.prio != PRIO_NONE) && (win.prio >= pend_q.prio)) begin
                        pend_d = win;
                    end
                end else begin
                    // Only flushes reach win here; they may override the buffered target.
                    if ((win.prio != PRIO_NONE) && (win.prio >= pend_q.prio)) begin
                        pc_d    = win.target;
                        flush_d = is_flush(win.prio);
                    end else begin
                        pc_d    = pend_q.target;
                        flush_d = is_flush(pend_q.prio);
                    end
                    pend_d = REDIR_NONE;
                end
            end
            default: begin
                pc_d   = PC_RESET_VEC;
                pend_d = REDIR_NONE;
            end
        endcase

        aligned = (pc_d[1:0] == 2'b00);
        en1_d   = (state_d != IDLE);
        en2_d   = en1_d && !pc_d[2] && aligned;
        exc_d   = en1_d && !aligned;
        cause_d = exc_d ? ECODE_ADEF : 7'd0;
        pc2_d   = pc_d + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= PC_RESET_VEC;
            pc2_q   <= PC_RESET_VEC + 32'd4;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            flush_q <= 1'b0;
            exc_q   <= 1'b0;
            cause_q <= 7'd0;
            pend_q  <= REDIR_NONE;
        end else begin
            pc_q    <= pc_d;
            pc2_q   <= pc2_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
            flush_q <= flush_d;
            exc_q   <= exc_d;
            cause_q <= cause_d;
            pend_q  <= pend_d;
        end
    end

    assign pc_o_1          = pc_q;
    assign pc_o_2          = pc2_q;
    assign inst_en_1       = en1_q;
    assign inst_en_2       = en2_q;
    assign fetch_flush     = flush_q;
    assign is_exception    = exc_q;
    assign exception_cause = cause_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with hand-computed expectations.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        excp_flush;
    logic [31:0] excp_target;
    logic        branch_flush;
    logic [31:0] branch_target;
    logic        pre_taken_or_not;
    logic [31:0] pre_branch_addr;
    logic [31:0] pc_o_1;
    logic [31:0] pc_o_2;
    logic        inst_en_1;
    logic        inst_en_2;
    logic        fetch_flush;
    logic        is_exception;
    logic [6:0]  exception_cause;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pc_redirect_ctrl #(.PC_RESET_VEC(32'h1C00_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .excp_flush       (excp_flush),
        .excp_target      (excp_target),
        .branch_flush     (branch_flush),
        .branch_target    (branch_target),
        .pre_taken_or_not (pre_taken_or_not),
        .pre_branch_addr  (pre_branch_addr),
        .pc_o_1           (pc_o_1),
        .pc_o_2           (pc_o_2),
        .inst_en_1        (inst_en_1),
        .inst_en_2        (inst_en_2),
        .fetch_flush      (fetch_flush),
        .is_exception     (is_exception),
        .exception_cause  (exception_cause)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall            = 1'b0;
        excp_flush       = 1'b0;
        excp_target      = 32'h0;
        branch_flush     = 1'b0;
        branch_target    = 32'h0;
        pre_taken_or_not = 1'b0;
        pre_branch_addr  = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0000) $display("FAIL rst_pc1 got %h want %h", pc_o_1, 32'h1C00_0000); else pass_cnt++;
        total_cnt++; if (pc_o_2 !== 32'h1C00_0004) $display("FAIL rst_pc2 got %h want %h", pc_o_2, 32'h1C00_0004); else pass_cnt++;
        total_cnt++; if ({inst_en_1, inst_en_2} !== 2'b00) $display("FAIL rst_en got %b want 00", {inst_en_1, inst_en_2}); else pass_cnt++;
        total_cnt++; if ({fetch_flush, is_exception} !== 2'b00) $display("FAIL rst_flush_exc got %b want 00", {fetch_flush, is_exception}); else pass_cnt++;
        total_cnt++; if (exception_cause !== 7'd0) $display("FAIL rst_cause got %h want 0", exception_cause); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        step();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0000) $display("FAIL seq0_pc got %h want %h", pc_o_1, 32'h1C00_0000); else pass_cnt++;
        total_cnt++; if ({inst_en_1, inst_en_2} !== 2'b11) $display("FAIL seq0_en got %b want 11", {inst_en_1, inst_en_2}); else pass_cnt++;
        step();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0008) $display("FAIL seq1_pc got %h want %h", pc_o_1, 32'h1C00_0008); else pass_cnt++;
        total_cnt++; if (inst_en_2 !== 1'b1) $display("FAIL seq1_en2 got %b want 1", inst_en_2); else pass_cnt++;
        step();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0010) $display("FAIL seq2_pc got %h want %h", pc_o_1, 32'h1C00_0010); else pass_cnt++;
        total_cnt++; if (pc_o_2 !== 32'h1C00_0014) $display("FAIL seq2_pc2 got %h want %h", pc_o_2, 32'h1C00_0014); else pass_cnt++;
    endtask

    task automatic test_branch();
        branch_flush  = 1'b1;
        branch_target = 32'h1C00_0104;
        step();
        clear_inputs();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0104) $display("FAIL br_pc got %h want %h", pc_o_1, 32'h1C00_0104); else pass_cnt++;
        total_cnt++; if ({inst_en_1, inst_en_2} !== 2'b10) $display("FAIL br_en got %b want 10", {inst_en_1, inst_en_2}); else pass_cnt++;
        total_cnt++; if (fetch_flush !== 1'b1) $display("FAIL br_flush got %b want 1", fetch_flush); else pass_cnt++;
        step();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0108) $display("FAIL br_next_pc got %h want %h", pc_o_1, 32'h1C00_0108); else pass_cnt++;
        total_cnt++; if (fetch_flush !== 1'b0) $display("FAIL br_flush_end got %b want 0", fetch_flush); else pass_cnt++;
        total_cnt++; if (inst_en_2 !== 1'b1) $display("FAIL br_next_en2 got %b want 1", inst_en_2); else pass_cnt++;
    endtask

    task automatic test_priority();
        excp_flush    = 1'b1;
        excp_target   = 32'h1C00_8000;
        branch_flush  = 1'b1;
        branch_target = 32'h1C00_0200;
        pre_taken_or_not = 1'b1;
        pre_branch_addr  = 32'h1C00_0300;
        step();
        clear_inputs();
        total_cnt++; if (pc_o_1 !== 32'h1C00_8000) $display("FAIL prio_pc got %h want %h", pc_o_1, 32'h1C00_8000); else pass_cnt++;
        total_cnt++; if (fetch_flush !== 1'b1) $display("FAIL prio_flush got %b want 1", fetch_flush); else pass_cnt++;
    endtask

    task automatic test_prediction();
        pre_taken_or_not = 1'b1;
        pre_branch_addr  = 32'h1C00_0040;
        step();
        clear_inputs();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0040) $display("FAIL pred_pc got %h want %h", pc_o_1, 32'h1C00_0040); else pass_cnt++;
        total_cnt++; if (fetch_flush !== 1'b0) $display("FAIL pred_flush got %b want 0", fetch_flush); else pass_cnt++;
    endtask

    task automatic test_stall_pend();
        stall            = 1'b1;
        pre_taken_or_not = 1'b1;
        pre_branch_addr  = 32'h1C00_0300;
        step();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0040) $display("FAIL stall1_pc got %h want %h", pc_o_1, 32'h1C00_0040); else pass_cnt++;
        pre_taken_or_not = 1'b0;
        branch_flush     = 1'b1;
        branch_target    = 32'h1C00_0400;
        step();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0040) $display("FAIL stall2_pc got %h want %h", pc_o_1, 32'h1C00_0040); else pass_cnt++;
        branch_flush = 1'b0;
        step();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0040) $display("FAIL stall3_pc got %h want %h", pc_o_1, 32'h1C00_0040); else pass_cnt++;
        total_cnt++; if (fetch_flush !== 1'b0) $display("FAIL stall3_flush got %b want 0", fetch_flush); else pass_cnt++;
        stall = 1'b0;
        step();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0400) $display("FAIL unstall_pc got %h want %h", pc_o_1, 32'h1C00_0400); else pass_cnt++;
        total_cnt++; if (fetch_flush !== 1'b1) $display("FAIL unstall_flush got %b want 1", fetch_flush); else pass_cnt++;
        step();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0408) $display("FAIL unstall_next_pc got %h want %h", pc_o_1, 32'h1C00_0408); else pass_cnt++;
    endtask

    task automatic test_pend_override();
        // Buffered branch overridden by an exception arriving on release.
        stall         = 1'b1;
        branch_flush  = 1'b1;
        branch_target = 32'h1C00_0500;
        step();
        branch_flush = 1'b0;
        stall        = 1'b0;
        excp_flush   = 1'b1;
        excp_target  = 32'h1C00_9000;
        step();
        clear_inputs();
        total_cnt++; if (pc_o_1 !== 32'h1C00_9000) $display("FAIL ovr_pc got %h want %h", pc_o_1, 32'h1C00_9000); else pass_cnt++;
        total_cnt++; if (fetch_flush !== 1'b1) $display("FAIL ovr_flush got %b want 1", fetch_flush); else pass_cnt++;
        // Prediction cannot displace a buffered exception.
        stall       = 1'b1;
        excp_flush  = 1'b1;
        excp_target = 32'h1C00_A000;
        step();
        excp_flush       = 1'b0;
        pre_taken_or_not = 1'b1;
        pre_branch_addr  = 32'h1C00_0600;
        step();
        clear_inputs();
        step();
        total_cnt++; if (pc_o_1 !== 32'h1C00_A000) $display("FAIL stale_pred_pc got %h want %h", pc_o_1, 32'h1C00_A000); else pass_cnt++;
        total_cnt++; if (fetch_flush !== 1'b1) $display("FAIL stale_pred_flush got %b want 1", fetch_flush); else pass_cnt++;
    endtask

    task automatic test_misaligned();
        pre_taken_or_not = 1'b1;
        pre_branch_addr  = 32'h1C00_0002;
        step();
        clear_inputs();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0002) $display("FAIL adef_pc got %h want %h", pc_o_1, 32'h1C00_0002); else pass_cnt++;
        total_cnt++; if (is_exception !== 1'b1) $display("FAIL adef_exc got %b want 1", is_exception); else pass_cnt++;
        total_cnt++; if (exception_cause !== 7'h08) $display("FAIL adef_cause got %h want %h", exception_cause, 7'h08); else pass_cnt++;
        total_cnt++; if ({inst_en_1, inst_en_2} !== 2'b10) $display("FAIL adef_en got %b want 10", {inst_en_1, inst_en_2}); else pass_cnt++;
        step();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0002) $display("FAIL adef_hold_pc got %h want %h", pc_o_1, 32'h1C00_0002); else pass_cnt++;
        branch_flush  = 1'b1;
        branch_target = 32'h1C00_0010;
        step();
        clear_inputs();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0010) $display("FAIL adef_rec_pc got %h want %h", pc_o_1, 32'h1C00_0010); else pass_cnt++;
        total_cnt++; if ({is_exception, exception_cause} !== 8'h00) $display("FAIL adef_rec_exc got %h want 00", {is_exception, exception_cause}); else pass_cnt++;
        total_cnt++; if (inst_en_2 !== 1'b1) $display("FAIL adef_rec_en2 got %b want 1", inst_en_2); else pass_cnt++;
    endtask

    task automatic test_wrap();
        excp_flush  = 1'b1;
        excp_target = 32'hFFFF_FFF8;
        step();
        clear_inputs();
        total_cnt++; if (pc_o_2 !== 32'hFFFF_FFFC) $display("FAIL wrap_pc2 got %h want %h", pc_o_2, 32'hFFFF_FFFC); else pass_cnt++;
        step();
        total_cnt++; if (pc_o_1 !== 32'h0000_0000) $display("FAIL wrap_pc got %h want %h", pc_o_1, 32'h0000_0000); else pass_cnt++;
        total_cnt++; if (pc_o_2 !== 32'h0000_0004) $display("FAIL wrap_pc2b got %h want %h", pc_o_2, 32'h0000_0004); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        branch_flush  = 1'b1;
        branch_target = 32'h1C00_0104;
        step();
        branch_target = 32'h1C00_0204;
        step();
        clear_inputs();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0204) $display("FAIL b2b_pc got %h want %h", pc_o_1, 32'h1C00_0204); else pass_cnt++;
        total_cnt++; if (fetch_flush !== 1'b1) $display("FAIL b2b_flush got %b want 1", fetch_flush); else pass_cnt++;
        step();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0208) $display("FAIL b2b_next_pc got %h want %h", pc_o_1, 32'h1C00_0208); else pass_cnt++;
        total_cnt++; if (fetch_flush !== 1'b0) $display("FAIL b2b_flush_end got %b want 0", fetch_flush); else pass_cnt++;
    endtask

    task automatic test_rst_pend();
        stall         = 1'b1;
        branch_flush  = 1'b1;
        branch_target = 32'h1C00_0700;
        step();
        rst   = 1'b1;
        stall = 1'b0;
        step();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0000) $display("FAIL rstp_pc got %h want %h", pc_o_1, 32'h1C00_0000); else pass_cnt++;
        total_cnt++; if ({inst_en_1, fetch_flush} !== 2'b00) $display("FAIL rstp_en_flush got %b want 00", {inst_en_1, fetch_flush}); else pass_cnt++;
        rst = 1'b0;
        clear_inputs();
        step();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0000) $display("FAIL rstp_fetch_pc got %h want %h", pc_o_1, 32'h1C00_0000); else pass_cnt++;
        total_cnt++; if ({inst_en_1, fetch_flush} !== 2'b10) $display("FAIL rstp_fetch_en got %b want 10", {inst_en_1, fetch_flush}); else pass_cnt++;
        step();
        total_cnt++; if (pc_o_1 !== 32'h1C00_0008) $display("FAIL rstp_seq_pc got %h want %h", pc_o_1, 32'h1C00_0008); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_priority();
        test_prediction();
        test_stall_pend();
        test_pend_override();
        test_misaligned();
        test_wrap();
        test_back_to_back();
        test_rst_pend();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
